menu_select_ctl: RTL and testbench

Parametrised successor to the PONG menu control stage. It draws N vertically stacked menu buttons over the incoming VGA stream and hit-tests the mouse against them. A press/release state machine emits a one-cycle selection pulse carrying the chosen item index. It sits in the pixel pipeline after the menu background stage and before the VGA output/control stage. All VGA timing signals are carried through it with fixed latency.

---
 rtl/menu_pkg.sv | 23 ++
 rtl/menu_hit_test.sv | 40 ++++
 rtl/menu_select_ctl.sv | 185 ++++++++++++++++++
 tb/tb_menu_select_ctl.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/menu_pkg.sv
// Shared types, default colours and geometry helpers for the menu selector.
package menu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_FIRE
    } state_e;

    localparam logic [11:0] COLOR_IDLE_DEF    = 12'h446;
    localparam logic [11:0] COLOR_HOVER_DEF   = 12'h88C;
    localparam logic [11:0] COLOR_PRESSED_DEF = 12'hFF0;

    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int ITEM_Y(input int y0, input int h,
                                  input int gap, input int k);
        return y0 + k * (h + gap);
    endfunction

endpackage

// File: rtl/menu_hit_test.sv
// Combinational point-in-button test over a vertical stack of N_ITEMS buttons.
module menu_hit_test
    import menu_pkg::*;
#(
    parameter int N_ITEMS = 3,
    parameter int BTN_X   = 412,
    parameter int BTN_W   = 200,
    parameter int BTN_Y0  = 200,
    parameter int BTN_H   = 60,
    parameter int BTN_GAP = 40,
    parameter int IW      = 2
) (
    input  logic [11:0]   x_i,
    input  logic [11:0]   y_i,
    output logic          hit_o,
    output logic [IW-1:0] idx_o
);

    logic [31:0] xv;
    logic [31:0] yv;
    logic        x_in;

    assign xv   = {20'd0, x_i};
    assign yv   = {20'd0, y_i};
    assign x_in = (xv >= 32'(BTN_X)) && (xv < 32'(BTN_X + BTN_W));

    always_comb begin
        hit_o = 1'b0;
        idx_o = '0;
        for (int k = 0; k < N_ITEMS; k++) begin
            if (x_in && !hit_o
                && yv >= 32'(ITEM_Y(BTN_Y0, BTN_H, BTN_GAP, k))
                && yv <  32'(ITEM_Y(BTN_Y0, BTN_H, BTN_GAP, k) + BTN_H)) begin
                hit_o = 1'b1;
                idx_o = IW'(k);
            end
        end
    end

endmodule

// File: rtl/menu_select_ctl.sv
// Menu button overlay and press/release selection FSM in the VGA pixel path.
module menu_select_ctl
    import menu_pkg::*;
#(
    parameter int          N_ITEMS       = 3,
    parameter int          BTN_X         = 412,
    parameter int          BTN_W         = 200,
    parameter int          BTN_Y0        = 200,
    parameter int          BTN_H         = 60,
    parameter int          BTN_GAP       = 40,
    parameter logic [11:0] COLOR_IDLE    = COLOR_IDLE_DEF,
    parameter logic [11:0] COLOR_HOVER   = COLOR_HOVER_DEF,
    parameter logic [11:0] COLOR_PRESSED = COLOR_PRESSED_DEF,
    localparam int         IW            = idx_width(N_ITEMS)
) (
    input  logic          pclk,
    input  logic          rst,
    input  logic          menu_active,
    input  logic [10:0]   vcount_in,
    input  logic [10:0]   hcount_in,
    input  logic          vsync_in,
    input  logic          hsync_in,
    input  logic          vblnk_in,
    input  logic          hblnk_in,
    input  logic [11:0]   rgb_in,
    input  logic [11:0]   xpos,
    input  logic [11:0]   ypos,
    input  logic          mouse_left,
    output logic [10:0]   vcount_out,
    output logic [10:0]   hcount_out,
    output logic          vsync_out,
    output logic          hsync_out,
    output logic          vblnk_out,
    output logic          hblnk_out,
    output logic [11:0]   rgb_out,
    output logic          select_valid,
    output logic [IW-1:0] select_idx
);

    if (N_ITEMS < 1 || N_ITEMS > 8) begin : g_bad_n
        $error("menu_select_ctl: N_ITEMS out of range");
    end
    if (ITEM_Y(BTN_Y0, BTN_H, BTN_GAP, N_ITEMS - 1) >= 2048) begin : g_bad_y
        $error("menu_select_ctl: item top edge beyond 2047");
    end

    state_e        state_q, state_d;
    logic [IW-1:0] press_idx_q, press_idx_d;
    logic [IW-1:0] sel_idx_q;
    logic          vblnk_q;
    logic [11:0]   mx_q, my_q;
    logic          mouse_left_q;
    logic          hover_valid_q;
    logic [IW-1:0] hover_idx_q;
    logic          m_hit;
    logic [IW-1:0] m_idx;
    logic          p_hit;
    logic [IW-1:0] p_idx;
    logic [10:0]   vc1_q, hc1_q;
    logic          vs1_q, hs1_q, vb1_q, hb1_q;
    logic [11:0]   rgb1_q;
    logic          hit1_q;
    logic [IW-1:0] idx1_q;
    logic [11:0]   rgb_d;
    logic          rise, fall;

    menu_hit_test #(
        .N_ITEMS(N_ITEMS), .BTN_X(BTN_X), .BTN_W(BTN_W),
        .BTN_Y0(BTN_Y0), .BTN_H(BTN_H), .BTN_GAP(BTN_GAP), .IW(IW)
    ) u_mouse_hit (
        .x_i(mx_q), .y_i(my_q), .hit_o(m_hit), .idx_o(m_idx)
    );

    menu_hit_test #(
        .N_ITEMS(N_ITEMS), .BTN_X(BTN_X), .BTN_W(BTN_W),
        .BTN_Y0(BTN_Y0), .BTN_H(BTN_H), .BTN_GAP(BTN_GAP), .IW(IW)
    ) u_pix_hit (
        .x_i({1'b0, hcount_in}), .y_i({1'b0, vcount_in}),
        .hit_o(p_hit), .idx_o(p_idx)
    );

    assign rise         = mouse_left && !mouse_left_q;
    assign fall         = !mouse_left && mouse_left_q;
    assign select_valid = (state_q == ST_FIRE) && menu_active;
    assign select_idx   = select_valid ? press_idx_q : sel_idx_q;

    always_comb begin
        state_d     = state_q;
        press_idx_d = press_idx_q;
        unique case (1'b1)
            (state_q == ST_IDLE): begin
                if (menu_active && rise && hover_valid_q) begin
                    state_d     = ST_ARMED;
                    press_idx_d = hover_idx_q;
                end
            end
            (state_q == ST_ARMED): begin
                if (!menu_active)
                    state_d = ST_IDLE;
                else if (fall)
                    state_d = (hover_valid_q && hover_idx_q == press_idx_q)
                              ? ST_FIRE : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Blanking beats everything; buttons draw only while the menu is shown.
    always_comb begin
        rgb_d = COLOR_IDLE;
        if (hb1_q || vb1_q)
            rgb_d = 12'h000;
        else if (!menu_active || !hit1_q)
            rgb_d = rgb1_q;
        else if (state_q == ST_ARMED && idx1_q == press_idx_q)
            rgb_d = COLOR_PRESSED;
        else if (hover_valid_q && idx1_q == hover_idx_q)
            rgb_d = COLOR_HOVER;
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            press_idx_q   <= '0;
            sel_idx_q     <= '0;
            vblnk_q       <= 1'b0;
            mx_q          <= '0;
            my_q          <= '0;
            mouse_left_q  <= 1'b1;
            hover_valid_q <= 1'b0;
            hover_idx_q   <= '0;
        end else begin
            state_q       <= state_d;
            press_idx_q   <= press_idx_d;
            sel_idx_q     <= select_idx;
            vblnk_q       <= vblnk_in;
            mouse_left_q  <= mouse_left;
            hover_valid_q <= m_hit;
            hover_idx_q   <= m_idx;
            if (vblnk_in && !vblnk_q) begin
                mx_q <= xpos;
                my_q <= ypos;
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            vc1_q      <= '0;
            hc1_q      <= '0;
            vs1_q      <= 1'b0;
            hs1_q      <= 1'b0;
            vb1_q      <= 1'b0;
            hb1_q      <= 1'b0;
            rgb1_q     <= '0;
            hit1_q     <= 1'b0;
            idx1_q     <= '0;
            vcount_out <= '0;
            hcount_out <= '0;
            vsync_out  <= 1'b0;
            hsync_out  <= 1'b0;
            vblnk_out  <= 1'b0;
            hblnk_out  <= 1'b0;
            rgb_out    <= '0;
        end else begin
            vc1_q      <= vcount_in;
            hc1_q      <= hcount_in;
            vs1_q      <= vsync_in;
            hs1_q      <= hsync_in;
            vb1_q      <= vblnk_in;
            hb1_q      <= hblnk_in;
            rgb1_q     <= rgb_in;
            hit1_q     <= p_hit;
            idx1_q     <= p_idx;
            vcount_out <= vc1_q;
            hcount_out <= hc1_q;
            vsync_out  <= vs1_q;
            hsync_out  <= hs1_q;
            vblnk_out  <= vb1_q;
            hblnk_out  <= hb1_q;
            rgb_out    <= rgb_d;
        end
    end

endmodule

// File: tb/tb_menu_select_ctl.sv
// Directed bench for menu_select_ctl with hand-computed expectations.
module tb_menu_select_ctl;

    logic        pclk = 1'b0;
    logic        rst;
    logic        menu_active;
    logic [10:0] vcount_in, hcount_in;
    logic        vsync_in, hsync_in, vblnk_in, hblnk_in;
    logic [11:0] rgb_in;
    logic [11:0] xpos, ypos;
    logic        mouse_left;
    logic [10:0] vcount_out, hcount_out;
    logic        vsync_out, hsync_out, vblnk_out, hblnk_out;
    logic [11:0] rgb_out;
    logic        select_valid;
    logic [1:0]  select_idx;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [11:0] BG = 12'hABC;

    menu_select_ctl dut (
        .pclk(pclk), .rst(rst), .menu_active(menu_active),
        .vcount_in(vcount_in), .hcount_in(hcount_in),
        .vsync_in(vsync_in), .hsync_in(hsync_in),
        .vblnk_in(vblnk_in), .hblnk_in(hblnk_in),
        .rgb_in(rgb_in), .xpos(xpos), .ypos(ypos),
        .mouse_left(mouse_left),
        .vcount_out(vcount_out), .hcount_out(hcount_out),
        .vsync_out(vsync_out), .hsync_out(hsync_out),
        .vblnk_out(vblnk_out), .hblnk_out(hblnk_out),
        .rgb_out(rgb_out), .select_valid(select_valid),
        .select_idx(select_idx)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    task automatic set_pix(input int h, input int v);
        hcount_in = 11'(h);
        vcount_in = 11'(v);
    endtask

    task automatic latch(input int x, input int y);
        xpos     = 12'(x);
        ypos     = 12'(y);
        vblnk_in = 1'b1;
        tick(1);
        vblnk_in = 1'b0;
        tick(1);
    endtask

    task automatic pix_chk(input string tag, input int h, input int v,
                           input logic [11:0] exp);
        set_pix(h, v);
        tick(2);
        chk(tag, rgb_out, exp);
    endtask

    initial begin
        rst = 1'b1; menu_active = 1'b1;
        vcount_in = '0; hcount_in = '0;
        vsync_in = 1'b0; hsync_in = 1'b0;
        vblnk_in = 1'b0; hblnk_in = 1'b0;
        rgb_in = BG; xpos = '0; ypos = '0;
        mouse_left = 1'b1;
        set_pix(500, 320);
        tick(3);
        chk("rst_rgb", rgb_out, 0);
        chk("rst_hcount", hcount_out, 0);
        chk("rst_valid", select_valid, 0);
        chk("rst_idx", select_idx, 0);
        rst = 1'b0;

        hsync_in = 1'b1;
        tick(2);
        chk("pipe_rgb", rgb_out, 12'h446);
        chk("pipe_hcount", hcount_out, 500);
        chk("pipe_vcount", vcount_out, 320);
        chk("pipe_hsync", hsync_out, 1);
        hsync_in = 1'b0;

        latch(450, 330);
        chk("blank_rgb", rgb_out, 0);
        chk("blank_vblnk", vblnk_out, 1);
        tick(1);
        chk("hover_rgb", rgb_out, 12'h88C);
        chk("held_no_arm", select_valid, 0);

        mouse_left = 1'b0;
        tick(1);
        chk("rel0_valid", select_valid, 0);
        mouse_left = 1'b1;
        tick(2);
        chk("press_rgb", rgb_out, 12'hFF0);
        mouse_left = 1'b0;
        tick(1);
        chk("fire_valid", select_valid, 1);
        chk("fire_idx", select_idx, 1);
        tick(1);
        chk("post_valid", select_valid, 0);
        chk("post_idx", select_idx, 1);
        chk("post_rgb", rgb_out, 12'h88C);

        latch(450, 220);
        mouse_left = 1'b1;
        tick(1);
        pix_chk("arm0_rgb", 500, 220, 12'hFF0);
        latch(450, 420);
        mouse_left = 1'b0;
        tick(1);
        chk("cancel_valid", select_valid, 0);
        tick(1);
        chk("cancel_valid2", select_valid, 0);
        chk("cancel_idx", select_idx, 1);
        pix_chk("cancel_rgb0", 500, 220, 12'h446);
        pix_chk("cancel_rgb2", 500, 420, 12'h88C);

        latch(612, 230);
        pix_chk("edge_611", 611, 259, 12'h446);
        pix_chk("edge_612", 612, 259, BG);
        pix_chk("edge_y260", 500, 260, BG);
        pix_chk("edge_lo", 412, 200, 12'h446);
        mouse_left = 1'b1;
        tick(1);
        mouse_left = 1'b0;
        tick(1);
        chk("miss_valid", select_valid, 0);
        pix_chk("miss_rgb", 500, 220, 12'h446);

        latch(450, 330);
        mouse_left = 1'b1;
        tick(1);
        pix_chk("arm1_rgb", 500, 320, 12'hFF0);
        menu_active = 1'b0;
        tick(1);
        chk("inact_rgb", rgb_out, BG);
        mouse_left = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk("inact_valid", select_valid, 0);
            chk("inact_rgb_loop", rgb_out, BG);
        end
        menu_active = 1'b1;
        pix_chk("reidle_rgb", 500, 320, 12'h88C);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
